multi_port_rfile: RTL and testbench
===================================

// Module: multi_port_rfile
// PURPOSE
//  Parametrised register-file macro: NREAD synchronous read ports and one masked write port.
//  Each read port latches its address on ren and holds it; it keeps presenting mem[held addr].
//  Optional output register; per-port read-valid; clear-on-reset init sequencer.
//  Sits under datapath/cache-tag modules as the generic storage primitive.
// PARAMETERS
//  WIDTH      65   data bits per entry
//  DEPTH      256  entries; need not be a power of 2
//  NREAD      2    read ports (>=1)
//  MASK_GRAN  13   bits per write-mask lane; WIDTH % MASK_GRAN must be 0 (elaboration error otherwise)
//  OUT_REG    0    1 = extra output register stage on rdata/rvalid
//  CLEAR_INIT 1    1 = zero all entries after reset; 0 = skip init
//  AW = max(1,clog2(DEPTH)); NM = WIDTH/MASK_GRAN (derived, not overridable)
// PORTS
//  clk        in   1            single clock, all state on posedge
//  reset      in   1            synchronous, active-high
//  io_busy    out  1            init sequence in progress
//  io_wen     in   1            write enable
//  io_waddr   in   AW           write address
//  io_wdata   in   WIDTH        write data
//  io_wmask   in   NM           lane k enables bits [k*MASK_GRAN +: MASK_GRAN]
//  io_ren     in   NREAD        per-port read enable (latch new address)
//  io_raddr   in   NREAD*AW     port i address at [i*AW +: AW]
//  io_rdata   out  NREAD*WIDTH  port i data at [i*WIDTH +: WIDTH]
//  io_rvalid  out  NREAD        port i: rdata corresponds to a ren issued LAT cycles earlier
// BEHAVIOUR
//  - Reset: state<=S_INIT (S_RUN if CLEAR_INIT=0), init ptr<=0, all held addrs<=0, rvalid<=0, out regs<=0.
//  - S_INIT: write 0 to mem[ptr] each cycle, ptr++; after ptr==DEPTH-1 -> S_RUN. Busy exactly DEPTH cycles.
//    io_busy=1; io_wen and io_ren ignored; rvalid=0.
//  - Reset asserted in any state (incl. mid-init) restarts the sequence from ptr=0; in-flight rvalid cleared.
//  - Read, OUT_REG=0 (LAT=1): ren[i] at cycle t -> raddr_q[i]<=raddr[i]; from t+1, rdata[i]=mem[raddr_q[i]]
//    combinationally; rvalid[i]=1 in t+1 only.
//  - Read, OUT_REG=1 (LAT=2): rdata/rvalid pass through one more register; data valid t+2.
//  - ren low: raddr_q holds; rdata keeps tracking mem[raddr_q], including later writes (LAT applies).
//  - Write: io_wen at t commits masked lanes on posedge ending t; unmasked lanes keep old value.
//  - Same-cycle write+ren to same addr: write-first; port reads the new data at t+LAT.
//  - Multiple ports same address: all return identical data; no arbitration, no stalls.
//  - Out-of-range addr (>=DEPTH): write dropped; read returns all-zero (rvalid still asserts).
//  - No X on outputs after reset: rdata=0 until first valid read.
// STRUCTURE
//  - Package rfile_pkg: state enum {S_INIT, S_RUN}; function clog2; lane-mask expand function.
//  - Sub-module rfile_read_port (address hold reg, range check, optional out reg, rvalid pipe),
//    generate-instantiated NREAD times; top holds array, write/mask logic, init FSM.
// TESTING
//  - Reset then idle: io_busy high exactly 256 cycles; then reads of addr 0,128,255 -> 0, rvalid after 1 cycle.
//  - Write addr 5 data 65'h1_DEAD_BEEF_0123_4567 mask 5'h1F; ren0 addr 5 next cycle -> that value at t+1.
//  - Mask 5'b00001 write all-ones over zero entry -> rdata = 65'h1FFF (low 13 bits only).
//  - Port0 ren addr 7 once, then ren low; write addr 7 = 65'h42 -> rdata0 changes to 65'h42 without new ren.
//  - Same cycle wen addr 9 = 65'hAA and ren0/ren1 addr 9 -> both ports show 65'hAA, rvalid=2'b11.
//  - Reset pulsed at init ptr=100 -> busy persists a full 256 further cycles; OUT_REG=1 build: latency 2.

Source files
------------

// File: rtl/rfile_pkg.sv
// Shared types and elaboration helpers for the multi-port register file.
package rfile_pkg;

    typedef enum logic [0:0] {S_INIT, S_RUN} state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // Write-mask lane that owns data bit bit_idx.
    function automatic int mask_lane(input int bit_idx, input int gran);
        return bit_idx / gran;
    endfunction

endpackage

// File: rtl/rfile_read_port.sv
// One read port: holds its address after ren, gates out-of-range reads to zero,
// optional output register and matching valid pipeline.
module rfile_read_port #(
    parameter int WIDTH   = 65,
    parameter int DEPTH   = 256,
    parameter int AW      = 8,
    parameter int OUT_REG = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ren,
    input  logic [AW-1:0]    raddr,
    output logic [AW-1:0]    mem_idx,
    input  logic [WIDTH-1:0] mem_word,
    output logic [WIDTH-1:0] rdata,
    output logic             rvalid
);
    localparam int LAT    = (OUT_REG != 0) ? 2 : 1;
    localparam int STAGES = LAT - 1;
    localparam logic [AW:0] DEPTH_X = (AW+1)'(DEPTH);

    logic [AW-1:0]    addr_q;
    logic             hit_q;
    logic [STAGES:0]  vld_pipe;
    logic [WIDTH-1:0] rd_word;

    // hit_q: a read has been issued since reset and its address is in range.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q <= '0;
            hit_q  <= 1'b0;
        end else if (ren) begin
            addr_q <= raddr;
            hit_q  <= ({1'b0, raddr} < DEPTH_X);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe[0] <= ren;
            for (int s = 1; s <= STAGES; s++) vld_pipe[s] <= vld_pipe[s-1];
        end
    end

    assign mem_idx = hit_q ? addr_q : '0;
    assign rd_word = hit_q ? mem_word : '0;
    assign rvalid  = vld_pipe[STAGES];

    if (OUT_REG != 0) begin : g_oreg
        logic [WIDTH-1:0] data_q;
        always_ff @(posedge clk) begin
            if (reset) data_q <= '0;
            else       data_q <= rd_word;
        end
        assign rdata = data_q;
    end else begin : g_comb
        assign rdata = rd_word;
    end

endmodule

// File: rtl/multi_port_rfile.sv
// Register file with NREAD held-address read ports, one lane-masked write port
// and an optional zero-fill sequencer that runs after every reset.
module multi_port_rfile
    import rfile_pkg::*;
#(
    parameter int WIDTH      = 65,
    parameter int DEPTH      = 256,
    parameter int NREAD      = 2,
    parameter int MASK_GRAN  = 13,
    parameter int OUT_REG    = 0,
    parameter int CLEAR_INIT = 1,
    localparam int AW = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH),
    localparam int NM = WIDTH / MASK_GRAN
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic                   io_busy,
    input  logic                   io_wen,
    input  logic [AW-1:0]          io_waddr,
    input  logic [WIDTH-1:0]       io_wdata,
    input  logic [NM-1:0]          io_wmask,
    input  logic [NREAD-1:0]       io_ren,
    input  logic [NREAD*AW-1:0]    io_raddr,
    output logic [NREAD*WIDTH-1:0] io_rdata,
    output logic [NREAD-1:0]       io_rvalid
);
    if (WIDTH % MASK_GRAN != 0) begin : g_bad_gran
        $error("multi_port_rfile: WIDTH must be a multiple of MASK_GRAN");
    end
    if (NREAD < 1) begin : g_bad_nread
        $error("multi_port_rfile: NREAD must be at least 1");
    end

    localparam state_t        S_RST   = (CLEAR_INIT != 0) ? S_INIT : S_RUN;
    localparam logic [AW:0]   DEPTH_X = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

    state_t                        state, state_nx;
    logic [AW-1:0]                 init_ptr;
    logic                          init_we, run;
    logic [WIDTH-1:0]              mem [DEPTH];
    logic [WIDTH-1:0]              wbits;
    logic                          wr_ok;
    logic [NREAD-1:0]              ren_ok;
    logic [NREAD-1:0][AW-1:0]      rd_idx;
    logic [NREAD-1:0][WIDTH-1:0]   rd_word;
    logic [NREAD-1:0][WIDTH-1:0]   rdata_p;

    always_ff @(posedge clk) begin
        if (reset) state <= S_RST;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (state == S_INIT && init_ptr == LAST) state_nx = S_RUN;
    end

    always_comb begin
        io_busy = (state == S_INIT);
        init_we = (state == S_INIT);
        run     = (state == S_RUN);
    end

    always_ff @(posedge clk) begin
        if (reset)        init_ptr <= '0;
        else if (init_we) init_ptr <= init_ptr + AW'(1);
    end

    for (genvar b = 0; b < WIDTH; b++) begin : g_mask
        assign wbits[b] = io_wmask[mask_lane(b, MASK_GRAN)];
    end

    // Out-of-range writes are dropped; the reset cycle never commits a user write.
    assign wr_ok = run && io_wen && !reset && ({1'b0, io_waddr} < DEPTH_X);

    always_ff @(posedge clk) begin
        if (init_we)
            mem[init_ptr] <= '0;
        else if (wr_ok)
            mem[io_waddr] <= (mem[io_waddr] & ~wbits) | (io_wdata & wbits);
    end

    assign ren_ok = io_ren & {NREAD{run}};

    for (genvar i = 0; i < NREAD; i++) begin : g_port
        assign rd_word[i] = mem[rd_idx[i]];
        rfile_read_port #(
            .WIDTH  (WIDTH),
            .DEPTH  (DEPTH),
            .AW     (AW),
            .OUT_REG(OUT_REG)
        ) u_port (
            .clk     (clk),
            .reset   (reset),
            .ren     (ren_ok[i]),
            .raddr   (io_raddr[i*AW +: AW]),
            .mem_idx (rd_idx[i]),
            .mem_word(rd_word[i]),
            .rdata   (rdata_p[i]),
            .rvalid  (io_rvalid[i])
        );
    end

    assign io_rdata = rdata_p;

endmodule

// File: tb/tb_multi_port_rfile.sv
// Bench for multi_port_rfile: a combinational-output build and an output-register
// build share one stimulus stream and are checked against an array model.
module tb_multi_port_rfile;
    localparam int W  = 65;
    localparam int D  = 256;
    localparam int NR = 2;
    localparam int AW = 8;
    localparam int NM = 5;
    localparam logic [W-1:0] DV   = 65'h1_DEAD_BEEF_0123_4567;
    localparam logic [W-1:0] ONES = {W{1'b1}};

    logic              clk = 1'b0;
    logic              reset;
    logic              wen;
    logic [AW-1:0]     waddr;
    logic [W-1:0]      wdata;
    logic [NM-1:0]     wmask;
    logic [NR-1:0]     ren;
    logic [NR*AW-1:0]  raddr;
    logic              busy_a, busy_b;
    logic [NR*W-1:0]   rdata_a, rdata_b;
    logic [NR-1:0]     rvalid_a, rvalid_b;

    always #5 clk = ~clk;

    multi_port_rfile #(.OUT_REG(0)) u_a (
        .clk(clk), .reset(reset), .io_busy(busy_a), .io_wen(wen), .io_waddr(waddr),
        .io_wdata(wdata), .io_wmask(wmask), .io_ren(ren), .io_raddr(raddr),
        .io_rdata(rdata_a), .io_rvalid(rvalid_a));

    multi_port_rfile #(.OUT_REG(1)) u_b (
        .clk(clk), .reset(reset), .io_busy(busy_b), .io_wen(wen), .io_waddr(waddr),
        .io_wdata(wdata), .io_wmask(wmask), .io_ren(ren), .io_raddr(raddr),
        .io_rdata(rdata_b), .io_rvalid(rvalid_b));

    // Reference state: contents, per-port held address, and expected outputs
    // for the 1-cycle (e1) and 2-cycle (e2) builds.
    logic [W-1:0]  mm [D];
    int            held [NR];
    bit            seen [NR];
    int            busy_cnt;
    logic [W-1:0]  e1_d [NR];
    logic [W-1:0]  e2_d [NR];
    logic [NR-1:0] e1_v, e2_v;
    int            n_tests = 0;
    int            n_fail  = 0;

    typedef struct {
        logic          wen;
        logic [AW-1:0] waddr;
        logic [W-1:0]  wdata;
        logic [NM-1:0] wmask;
        logic [NR-1:0] ren;
        logic [AW-1:0] ra0, ra1;
        logic [NR-1:0] exp_v;
        logic [W-1:0]  exp0, exp1;
    } vec_t;
    vec_t vecs [8];

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic w, input int wa, input logic [W-1:0] wd,
                         input logic [NM-1:0] wm, input logic [NR-1:0] r, input int a0, input int a1);
        wen   = w;
        waddr = AW'(wa);
        wdata = wd;
        wmask = wm;
        ren   = r;
        raddr = {AW'(a1), AW'(a0)};
    endtask

    task automatic idle();
        drive(1'b0, 0, '0, '0, '0, 0, 0);
    endtask

    // Advance one clock: update the model from the current inputs, then compare.
    task automatic tick();
        bit acc;
        for (int i = 0; i < NR; i++) e2_d[i] = e1_d[i];
        e2_v = e1_v;
        if (reset) begin
            busy_cnt = D;
            e1_v = '0;
            e2_v = '0;
            for (int i = 0; i < NR; i++) begin
                held[i] = 0;
                seen[i] = 1'b0;
                e2_d[i] = '0;
            end
            for (int a = 0; a < D; a++) mm[a] = '0;
        end else begin
            acc = (busy_cnt == 0);
            if (busy_cnt > 0) busy_cnt--;
            if (acc && wen)
                for (int b = 0; b < W; b++)
                    if (wmask[b / 13]) mm[waddr][b] = wdata[b];
            for (int i = 0; i < NR; i++) begin
                e1_v[i] = acc && ren[i];
                if (e1_v[i]) begin
                    held[i] = int'(raddr[i*AW +: AW]);
                    seen[i] = 1'b1;
                end
            end
        end
        for (int i = 0; i < NR; i++) e1_d[i] = seen[i] ? mm[held[i]] : '0;
        @(posedge clk);
        #1;
        chk("busy_a", W'(busy_a), W'(busy_cnt > 0));
        chk("busy_b", W'(busy_b), W'(busy_cnt > 0));
        chk("rvalid_a", W'(rvalid_a), W'(e1_v));
        chk("rvalid_b", W'(rvalid_b), W'(e2_v));
        for (int i = 0; i < NR; i++) begin
            chk($sformatf("rdata_a[%0d]", i), rdata_a[i*W +: W], e1_d[i]);
            chk($sformatf("rdata_b[%0d]", i), rdata_b[i*W +: W], e2_d[i]);
        end
    endtask

    task automatic count_busy(input string name);
        int cnt;
        cnt = 0;
        while (busy_a === 1'b1 && cnt < 1000) begin
            cnt++;
            tick();
        end
        chk(name, W'(cnt), W'(D));
    endtask

    initial begin
        vecs[0] = '{1'b1, 8'd5,  DV,        5'h1F,    2'b00, 8'd0, 8'd0,   2'b00, '0,            '0};
        vecs[1] = '{1'b0, 8'd0,  '0,        5'h00,    2'b01, 8'd5, 8'd0,   2'b01, DV,            '0};
        vecs[2] = '{1'b1, 8'd20, ONES,      5'b00001, 2'b10, 8'd0, 8'd20,  2'b10, DV,            65'h1FFF};
        vecs[3] = '{1'b0, 8'd0,  '0,        5'h00,    2'b01, 8'd7, 8'd0,   2'b01, '0,            65'h1FFF};
        vecs[4] = '{1'b1, 8'd7,  65'h42,    5'h1F,    2'b00, 8'd0, 8'd0,   2'b00, 65'h42,        65'h1FFF};
        vecs[5] = '{1'b1, 8'd9,  65'hAA,    5'h1F,    2'b11, 8'd9, 8'd9,   2'b11, 65'hAA,        65'hAA};
        vecs[6] = '{1'b1, 8'd9,  ONES,      5'b00010, 2'b00, 8'd0, 8'd0,   2'b00, 65'h3FFE0AA,   65'h3FFE0AA};
        vecs[7] = '{1'b0, 8'd0,  '0,        5'h00,    2'b11, 8'd0, 8'd255, 2'b11, '0,            '0};

        reset = 1'b1;
        idle();
        tick();
        reset = 1'b0;
        count_busy("busy_len_after_reset");

        drive(1'b0, 0, '0, '0, 2'b11, 0, 128);
        tick();
        chk("rd_addr0", rdata_a[0 +: W], '0);
        chk("rd_addr128", rdata_a[W +: W], '0);
        chk("rv_first_reads", W'(rvalid_a), W'(2'b11));
        drive(1'b0, 0, '0, '0, 2'b01, 255, 0);
        tick();
        chk("rd_addr255", rdata_a[0 +: W], '0);

        for (int v = 0; v < 8; v++) begin
            drive(vecs[v].wen, int'(vecs[v].waddr), vecs[v].wdata, vecs[v].wmask,
                  vecs[v].ren, int'(vecs[v].ra0), int'(vecs[v].ra1));
            tick();
            chk($sformatf("vec%0d_rdata0", v), rdata_a[0 +: W], vecs[v].exp0);
            chk($sformatf("vec%0d_rdata1", v), rdata_a[W +: W], vecs[v].exp1);
            chk($sformatf("vec%0d_rvalid", v), W'(rvalid_a), W'(vecs[v].exp_v));
        end

        // Output-register build: data and valid arrive two cycles after ren.
        idle();
        tick();
        drive(1'b0, 0, '0, '0, 2'b01, 5, 0);
        tick();
        chk("lat2_rvalid_t1", W'(rvalid_b[0]), '0);
        idle();
        tick();
        chk("lat2_rvalid_t2", W'(rvalid_b[0]), W'(1'b1));
        chk("lat2_rdata_t2", rdata_b[0 +: W], DV);

        // Reset mid-init restarts the full clear sequence.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int k = 0; k < 100; k++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        count_busy("busy_len_after_mid_reset");

        for (int n = 0; n < 1500; n++) begin
            reset = ($urandom_range(0, 399) == 0);
            drive(1'(($urandom_range(0, 1))),
                  ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, D-1)) : int'($urandom_range(0, 15)),
                  {1'($urandom_range(0, 1)), $urandom, $urandom},
                  NM'($urandom_range(0, 31)),
                  NR'($urandom_range(0, 3)),
                  int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
            tick();
        end
        reset = 1'b0;
        idle();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
